// File: rtl/riscv_pkg.sv
// Shared Ludi-V encodings: result sources, load/store funct3 values and the
// memory-stage state constants.
package riscv_pkg;

  localparam logic [1:0] ALU_RESULT = 2'b00;
  localparam logic [1:0] MEM_TO_REG = 2'b01;
  localparam logic [1:0] PC_PLUS    = 2'b10;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t ST_IDLE     = 2'd0;
  localparam mem_state_t ST_REQ      = 2'd1;
  localparam mem_state_t ST_WAIT_RSP = 2'd2;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, and
// detection of misaligned or undefined accesses.
module load_store_align
  import riscv_pkg::*;
(
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte     = load_word[{offset, 3'b000} +: 8];
    ld_half     = offset[1] ? load_word[31:16] : load_word[15:0];
    byte_en     = 4'b0000;
    store_lanes = store_data;
    load_data   = 32'h0;
    fault       = 1'b0;

    case (funct3[1:0])
      2'b00:   byte_en = 4'b0001 << offset;
      2'b01:   byte_en = 4'b0011 << offset;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase

    case (funct3)
      SB:      store_lanes = {4{store_data[7:0]}};
      SH:      store_lanes = {2{store_data[15:0]}};
      default: store_lanes = store_data;
    endcase

    case (funct3)
      LB:      load_data = {{24{ld_byte[7]}}, ld_byte};
      LH:      load_data = {{16{ld_half[15]}}, ld_half};
      LW:      load_data = load_word;
      LBU:     load_data = {24'h0, ld_byte};
      LHU:     load_data = {16'h0, ld_half};
      default: load_data = 32'h0;
    endcase

    // A simultaneous load and store is never a legal instruction.
    if (mem_read && mem_write) begin
      fault = 1'b1;
    end else if (mem_read) begin
      case (funct3)
        LB, LBU: fault = 1'b0;
        LH, LHU: fault = offset[0];
        LW:      fault = |offset;
        default: fault = 1'b1;
      endcase
    end else if (mem_write) begin
      case (funct3)
        SB:      fault = 1'b0;
        SH:      fault = offset[0];
        SW:      fault = |offset;
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/stage_memory.sv
// Ludi-V memory-access stage: issues load/store requests on the data bus,
// stalls execute while an access is outstanding and registers the writeback bundle.
module stage_memory
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  ex_result_src,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_write_data,
  input  logic [31:0] ex_instr_addr_plus,
  input  logic        ex_wr_enable,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  output logic        mem_stall,
  output logic [4:0]  mem_rd,
  output logic [1:0]  mem_result_src,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_read_data,
  output logic [31:0] mem_instr_addr_plus,
  output logic        mem_wr_enable,
  output logic        mem_fault,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ready,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  mem_state_t  state;
  logic [4:0]  hold_rd;
  logic [1:0]  hold_result_src;
  logic [31:0] hold_alu;
  logic [31:0] hold_pc_plus;
  logic        hold_wr_en;
  logic [2:0]  hold_funct3;
  logic        hold_is_store;
  logic        in_idle;
  logic        is_mem;
  logic        align_read;
  logic        align_write;
  logic [2:0]  align_funct3;
  logic [1:0]  align_offset;
  logic [3:0]  align_be;
  logic [31:0] align_lanes;
  logic [31:0] align_load;
  logic        align_fault;

  assign in_idle   = (state == ST_IDLE);
  assign is_mem    = ex_mem_read | ex_mem_write;
  assign mem_stall = !in_idle;
  assign dbus_req  = (state == ST_REQ);

  // The aligner checks the incoming instruction while idle and decodes the
  // held access while it is in flight.
  assign align_read   = in_idle ? ex_mem_read : !hold_is_store;
  assign align_write  = in_idle ? ex_mem_write : hold_is_store;
  assign align_funct3 = in_idle ? ex_funct3 : hold_funct3;
  assign align_offset = in_idle ? ex_alu_result[1:0] : hold_alu[1:0];

  load_store_align u_align (
    .mem_read    (align_read),
    .mem_write   (align_write),
    .funct3      (align_funct3),
    .offset      (align_offset),
    .store_data  (ex_write_data),
    .load_word   (dbus_rdata),
    .byte_en     (align_be),
    .store_lanes (align_lanes),
    .load_data   (align_load),
    .fault       (align_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      hold_rd             <= '0;
      hold_result_src     <= '0;
      hold_alu            <= '0;
      hold_pc_plus        <= '0;
      hold_wr_en          <= 1'b0;
      hold_funct3         <= '0;
      hold_is_store       <= 1'b0;
      mem_rd              <= '0;
      mem_result_src      <= '0;
      mem_alu_result      <= '0;
      mem_read_data       <= '0;
      mem_instr_addr_plus <= '0;
      mem_wr_enable       <= 1'b0;
      mem_fault           <= 1'b0;
      dbus_we             <= 1'b0;
      dbus_addr           <= '0;
      dbus_be             <= '0;
      dbus_wdata          <= '0;
    end else begin
      mem_wr_enable <= 1'b0;
      mem_fault     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!is_mem || align_fault) begin
              mem_rd              <= ex_rd;
              mem_result_src      <= ex_result_src;
              mem_alu_result      <= ex_alu_result;
              mem_instr_addr_plus <= ex_instr_addr_plus;
              mem_read_data       <= '0;
              mem_wr_enable       <= ex_wr_enable & !align_fault;
              mem_fault           <= align_fault;
            end else begin
              hold_rd         <= ex_rd;
              hold_result_src <= ex_result_src;
              hold_alu        <= ex_alu_result;
              hold_pc_plus    <= ex_instr_addr_plus;
              hold_wr_en      <= ex_wr_enable;
              hold_funct3     <= ex_funct3;
              hold_is_store   <= ex_mem_write;
              dbus_we         <= ex_mem_write;
              dbus_addr       <= {ex_alu_result[31:2], 2'b00};
              dbus_be         <= align_be;
              dbus_wdata      <= ex_mem_write ? align_lanes : 32'h0;
              state           <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dbus_ready) begin
            if (hold_is_store) begin
              mem_rd              <= hold_rd;
              mem_result_src      <= hold_result_src;
              mem_alu_result      <= hold_alu;
              mem_instr_addr_plus <= hold_pc_plus;
              mem_read_data       <= '0;
              mem_wr_enable       <= hold_wr_en;
              state               <= ST_IDLE;
            end else begin
              state <= ST_WAIT_RSP;
            end
          end
        end
        ST_WAIT_RSP: begin
          if (dbus_rvalid) begin
            mem_rd              <= hold_rd;
            mem_result_src      <= hold_result_src;
            mem_alu_result      <= hold_alu;
            mem_instr_addr_plus <= hold_pc_plus;
            mem_read_data       <= align_load;
            mem_wr_enable       <= hold_wr_en;
            state               <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed vector table, reset and
// back-to-back sequences, then random accesses against a reference model.
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_result_src;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_write_data;
  logic [31:0] ex_instr_addr_plus;
  logic        ex_wr_enable;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        mem_stall;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic [31:0] mem_instr_addr_plus;
  logic        mem_wr_enable;
  logic        mem_fault;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ready;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  int assertCount = 0;
  int failCount   = 0;

  stage_memory dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ex_valid           (ex_valid),
    .ex_rd              (ex_rd),
    .ex_result_src      (ex_result_src),
    .ex_alu_result      (ex_alu_result),
    .ex_write_data      (ex_write_data),
    .ex_instr_addr_plus (ex_instr_addr_plus),
    .ex_wr_enable       (ex_wr_enable),
    .ex_mem_read        (ex_mem_read),
    .ex_mem_write       (ex_mem_write),
    .ex_funct3          (ex_funct3),
    .mem_stall          (mem_stall),
    .mem_rd             (mem_rd),
    .mem_result_src     (mem_result_src),
    .mem_alu_result     (mem_alu_result),
    .mem_read_data      (mem_read_data),
    .mem_instr_addr_plus(mem_instr_addr_plus),
    .mem_wr_enable      (mem_wr_enable),
    .mem_fault          (mem_fault),
    .dbus_req           (dbus_req),
    .dbus_we            (dbus_we),
    .dbus_addr          (dbus_addr),
    .dbus_be            (dbus_be),
    .dbus_wdata         (dbus_wdata),
    .dbus_ready         (dbus_ready),
    .dbus_rvalid        (dbus_rvalid),
    .dbus_rdata         (dbus_rdata)
  );

  always #5 clk = ~clk;

  // kind: 0 = ALU op, 1 = load, 2 = store, 3 = load and store together
  typedef struct {
    int          kind;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          readyDelay;
    bit          expFault;
    logic [3:0]  expBe;
    logic [31:0] expLanes;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBundle(input logic [4:0] rd, input logic [1:0] rs, input logic [31:0] alu,
                             input logic [31:0] pc4, input logic wr, input logic [31:0] rdata);
    checkOutput("mem_rd", mem_rd, rd);
    checkOutput("mem_result_src", mem_result_src, rs);
    checkOutput("mem_alu_result", mem_alu_result, alu);
    checkOutput("mem_instr_addr_plus", mem_instr_addr_plus, pc4);
    checkOutput("mem_wr_enable", mem_wr_enable, wr);
    checkOutput("mem_read_data", mem_read_data, rdata);
  endtask

  // Reference model: access size from funct3, alignment by divisibility,
  // lanes by byte replication, load value by shift/mask and two's complement.
  function automatic void modelAccess(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [31:0] rdata,
                                      output bit fault, output logic [3:0] be,
                                      output logic [31:0] lanes, output logic [31:0] rdVal);
    int size = 0;
    bit sgn = 0;
    int o = int'(addr % 4);
    longint v;
    fault = 0; be = '0; lanes = '0; rdVal = '0;
    if (kind == 0) return;
    if (kind == 1) begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end else if (kind == 2) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end
    if (size == 0) fault = 1;
    else fault = (o % size) != 0;
    if (fault) return;
    for (int i = 0; i < size; i++) be[o + i] = 1'b1;
    if (kind == 2) for (int i = 0; i < 4; i++) lanes[8*i +: 8] = wdata[8*(i % size) +: 8];
    if (kind == 1) begin
      v = longint'(rdata >> (8 * o)) & ((longint'(1) << (8 * size)) - 1);
      if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
      rdVal = v[31:0];
    end
  endfunction

  // Entered and left just after a rising edge; samples on falling edges.
  task automatic applyStimulus(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd,
                               input logic wr, input int readyDelay, input int rvalidDelay,
                               input bit expFault, input logic [3:0] expBe,
                               input logic [31:0] expLanes, input logic [31:0] expRead);
    logic [1:0]  rs  = 2'($urandom_range(0, 2));
    logic [31:0] pc4 = $urandom;
    ex_rd = rd; ex_result_src = rs; ex_alu_result = addr; ex_write_data = wdata;
    ex_instr_addr_plus = pc4; ex_wr_enable = wr; ex_funct3 = f3;
    ex_mem_read  = (kind == 1 || kind == 3);
    ex_mem_write = (kind == 2 || kind == 3);
    ex_valid = 1'b1;
    @(posedge clk); #1 ex_valid = 1'b0;
    if (kind == 0 || expFault) begin
      @(negedge clk);
      checkBundle(rd, rs, addr, pc4, expFault ? 1'b0 : wr, 32'h0);
      checkOutput("mem_fault", mem_fault, expFault);
      checkOutput("no_dbus_req", dbus_req, 1'b0);
      checkOutput("mem_stall", mem_stall, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("fault_pulse_end", mem_fault, 1'b0);
      checkOutput("bubble_after", mem_wr_enable, 1'b0);
      checkOutput("no_dbus_req_after", dbus_req, 1'b0);
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i < readyDelay; i++) begin
        dbus_rvalid = 1'b1; dbus_rdata = $urandom;
        @(negedge clk);
        checkOutput("req_held", dbus_req, 1'b1);
        checkOutput("stall_in_req", mem_stall, 1'b1);
        checkOutput("bubble_in_req", mem_wr_enable, 1'b0);
        checkOutput("addr_stable", dbus_addr, {addr[31:2], 2'b00});
        @(posedge clk); #1;
      end
      dbus_rvalid = 1'b0; dbus_ready = 1'b1;
      @(negedge clk);
      checkOutput("dbus_req", dbus_req, 1'b1);
      checkOutput("dbus_addr", dbus_addr, {addr[31:2], 2'b00});
      checkOutput("dbus_we", dbus_we, kind == 2);
      if (kind == 2) begin
        checkOutput("dbus_be", dbus_be, expBe);
        checkOutput("dbus_wdata", dbus_wdata, expLanes);
      end
      @(posedge clk); #1 dbus_ready = 1'b0;
      if (kind == 2) begin
        @(negedge clk);
        checkBundle(rd, rs, addr, pc4, wr, 32'h0);
        checkOutput("stall_done", mem_stall, 1'b0);
        checkOutput("req_done", dbus_req, 1'b0);
        @(posedge clk); #1;
      end else begin
        for (int i = 0; i < rvalidDelay; i++) begin
          @(negedge clk);
          checkOutput("stall_in_wait", mem_stall, 1'b1);
          checkOutput("no_req_in_wait", dbus_req, 1'b0);
          checkOutput("bubble_in_wait", mem_wr_enable, 1'b0);
          @(posedge clk); #1;
        end
        dbus_rvalid = 1'b1; dbus_rdata = rdata;
        @(posedge clk); #1 dbus_rvalid = 1'b0;
        @(negedge clk);
        checkBundle(rd, rs, addr, pc4, wr, expRead);
        checkOutput("stall_done", mem_stall, 1'b0);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bit          fault;
    logic [3:0]  be;
    logic [31:0] lanes, rdVal, addr, wdata, rdata;
    logic [2:0]  f3;
    int          kind, sel;

    vecs[0]  = '{0, 3'd0, 32'h1234,  32'h0,        32'h0,        5'd5,  0, 1'b0, 4'b0000, 32'h0,        32'h0};
    vecs[1]  = '{2, 3'd0, 32'h103,   32'hAB,       32'h0,        5'd0,  3, 1'b0, 4'b1000, 32'hABABABAB, 32'h0};
    vecs[2]  = '{1, 3'd0, 32'h2,     32'h0,        32'h00800000, 5'd7,  0, 1'b0, 4'b0000, 32'h0,        32'hFFFFFF80};
    vecs[3]  = '{1, 3'd4, 32'h2,     32'h0,        32'h00800000, 5'd8,  1, 1'b0, 4'b0000, 32'h0,        32'h00000080};
    vecs[4]  = '{1, 3'd2, 32'h6,     32'h0,        32'h0,        5'd9,  0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{1, 3'd1, 32'h3,     32'h0,        32'h0,        5'd10, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{2, 3'd1, 32'h2,     32'h1234BEEF, 32'h0,        5'd0,  1, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[7]  = '{1, 3'd1, 32'h2,     32'h0,        32'h80010000, 5'd11, 0, 1'b0, 4'b0000, 32'h0,        32'hFFFF8001};
    vecs[8]  = '{1, 3'd5, 32'h2,     32'h0,        32'h80010000, 5'd12, 2, 1'b0, 4'b0000, 32'h0,        32'h00008001};
    vecs[9]  = '{1, 3'd2, 32'h8,     32'h0,        32'hDEADBEEF, 5'd13, 0, 1'b0, 4'b0000, 32'h0,        32'hDEADBEEF};
    vecs[10] = '{1, 3'd3, 32'h0,     32'h0,        32'h0,        5'd14, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{2, 3'd4, 32'h0,     32'h0,        32'h0,        5'd0,  0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{3, 3'd2, 32'h0,     32'h0,        32'h0,        5'd15, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[13] = '{2, 3'd2, 32'h10,    32'hCAFEF00D, 32'h0,        5'd0,  0, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};

    rst_n = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_result_src = '0; ex_alu_result = '0;
    ex_write_data = '0; ex_instr_addr_plus = '0; ex_wr_enable = 1'b0; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_funct3 = '0; dbus_ready = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;

    @(negedge clk);
    checkBundle(5'd0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("reset_mem_fault", mem_fault, 1'b0);
    checkOutput("reset_stall", mem_stall, 1'b0);
    checkOutput("reset_dbus_req", dbus_req, 1'b0);
    checkOutput("reset_dbus_we", dbus_we, 1'b0);
    checkOutput("reset_dbus_addr", dbus_addr, 32'h0);
    checkOutput("reset_dbus_be", dbus_be, 4'h0);
    checkOutput("reset_dbus_wdata", dbus_wdata, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    foreach (vecs[i])
      applyStimulus(vecs[i].kind, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].rd,
                    vecs[i].kind != 2, vecs[i].readyDelay, i % 2, vecs[i].expFault,
                    vecs[i].expBe, vecs[i].expLanes, vecs[i].expRead);

    $display("[TB] reset during REQ");
    ex_rd = 5'd3; ex_alu_result = 32'h40; ex_funct3 = 3'd2; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_wr_enable = 1'b1; ex_valid = 1'b1;
    @(posedge clk); #1 ex_valid = 1'b0;
    @(negedge clk);
    checkOutput("req_before_reset", dbus_req, 1'b1);
    rst_n = 1'b0;
    #1 checkOutput("async_reset_req", dbus_req, 1'b0);
    checkOutput("async_reset_stall", mem_stall, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1 dbus_rvalid = 1'b0;
    @(negedge clk);
    checkBundle(5'd0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("req_after_reset", dbus_req, 1'b0);
    @(posedge clk); #1;

    $display("[TB] reset during WAIT_RSP");
    applyStimulus(0, 3'd0, 32'h99, 32'h0, 32'h0, 5'd2, 1'b1, 0, 0, 1'b0, 4'h0, 32'h0, 32'h0);
    ex_rd = 5'd4; ex_alu_result = 32'h44; ex_funct3 = 3'd2; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_wr_enable = 1'b1; ex_valid = 1'b1;
    @(posedge clk); #1 ex_valid = 1'b0; dbus_ready = 1'b1;
    @(posedge clk); #1 dbus_ready = 1'b0;
    @(negedge clk);
    checkOutput("wait_rsp_stall", mem_stall, 1'b1);
    checkOutput("wait_rsp_no_req", dbus_req, 1'b0);
    rst_n = 1'b0;
    #1 checkOutput("wait_reset_stall", mem_stall, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 dbus_rvalid = 1'b1; dbus_rdata = 32'h12345678;
    @(posedge clk); #1 dbus_rvalid = 1'b0;
    @(negedge clk);
    checkBundle(5'd0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("stale_rvalid_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    applyStimulus(0, 3'd0, 32'h55, 32'h0, 32'h0, 5'd6, 1'b1, 0, 0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("[TB] back-to-back LW then ADD");
    ex_rd = 5'd20; ex_result_src = 2'b01; ex_alu_result = 32'h80; ex_instr_addr_plus = 32'h1000;
    ex_funct3 = 3'd2; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_wr_enable = 1'b1; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_rd = 5'd21; ex_result_src = 2'b00; ex_alu_result = 32'h777; ex_instr_addr_plus = 32'h1004;
    ex_mem_read = 1'b0; dbus_ready = 1'b1;
    @(negedge clk);
    checkOutput("b2b_bubble_req", mem_wr_enable, 1'b0);
    checkOutput("b2b_stall_req", mem_stall, 1'b1);
    @(posedge clk); #1 dbus_ready = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    checkOutput("b2b_bubble_wait", mem_wr_enable, 1'b0);
    checkOutput("b2b_stall_wait", mem_stall, 1'b1);
    @(posedge clk); #1 dbus_rvalid = 1'b0;
    @(negedge clk);
    checkBundle(5'd20, 2'b01, 32'h80, 32'h1000, 1'b1, 32'hA5A5A5A5);
    @(posedge clk); #1 ex_valid = 1'b0;
    @(negedge clk);
    checkBundle(5'd21, 2'b00, 32'h777, 32'h1004, 1'b1, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b2b_no_duplicate", mem_wr_enable, 1'b0);
    @(posedge clk); #1;

    $display("[TB] random accesses");
    for (int n = 0; n < 60; n++) begin
      sel  = $urandom_range(0, 9);
      kind = (sel < 3) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3;
      f3   = (kind == 2) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      modelAccess(kind, f3, addr, wdata, rdata, fault, be, lanes, rdVal);
      applyStimulus(kind, f3, addr, wdata, rdata, 5'($urandom), 1'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 2), fault, be, lanes, rdVal);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
# stage_memory

Memory-access stage of the Ludi-V pipeline, between execute and writeback. It is the producer of the `mem_*` bundle that `stage_writeback` registers every clock. The stage performs RISC-V load/store accesses over a request/response data bus, aligns and sign-extends load data, and stalls upstream while an access is outstanding. Non-memory instructions pass through with one cycle of latency.

## Interface
- No parameters; all widths are fixed at 32-bit data and address and 5-bit register index.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: execute bundle valid.
- `ex_rd` in 5: destination register.
- `ex_result_src` in 2: result select, passed through unchanged.
- `ex_alu_result` in 32: ALU result; this is the effective address for loads and stores.
- `ex_write_data` in 32: store data (rs2).
- `ex_instr_addr_plus` in 32: PC+4.
- `ex_wr_enable` in 1: register write enable.
- `ex_mem_read`, `ex_mem_write` in 1 each: load or store. Both high together is illegal and is treated as a fault.
- `ex_funct3` in 3: access size and sign.
- `mem_stall` out 1: execute must hold its bundle.
- `mem_rd` out 5, `mem_result_src` out 2, `mem_alu_result` out 32, `mem_read_data` out 32, `mem_instr_addr_plus` out 32, `mem_wr_enable` out 1: registered bundle to writeback.
- `mem_fault` out 1: one-cycle pulse with a faulted instruction.
- `dbus_req` out 1, `dbus_we` out 1, `dbus_addr` out 32 (word-aligned), `dbus_be` out 4, `dbus_wdata` out 32: request channel.
- `dbus_ready` in 1: request accepted.
- `dbus_rvalid` in 1, `dbus_rdata` in 32: load response.

## Operation
- FSM states: IDLE, REQ, WAIT_RSP. `mem_stall` = (state != IDLE).
- IDLE behaviour when `ex_valid` is high:
  - Non-memory instruction: register the bundle, set `mem_read_data` = 0, stay in IDLE.
  - Fault (see below): register the bundle with `mem_wr_enable` = 0, pulse `mem_fault`, stay in IDLE, issue no bus access.
  - Legal load or store: capture the bundle into holding registers, emit a bubble, go to REQ.
- In IDLE with `ex_valid` low, emit a bubble.
- Bubble: `mem_wr_enable` = 0; other outputs hold their previous values.
- REQ:
  - `dbus_req` = 1; address, byte enables and write data are driven from the holding registers and stay stable until `dbus_ready`.
  - On `dbus_ready` for a store: register the bundle with `mem_read_data` = 0, go to IDLE.
  - On `dbus_ready` for a load: go to WAIT_RSP.
- WAIT_RSP: on `dbus_rvalid`, extract and extend the load data, register the bundle, go to IDLE.
- `dbus_rvalid` is ignored in IDLE and REQ.
- Bubbles are emitted in every cycle spent in REQ or WAIT_RSP.
- Fault conditions:
  - LH, LHU or SH with `addr[0]` = 1.
  - LW or SW with `addr[1:0]` != 0.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 above 010.
  - `ex_mem_read` and `ex_mem_write` both high.
- Store lanes, with o = `addr[1:0]`:
  - SB: `dbus_be` = 1<<o, and the byte is replicated to all four lanes.
  - SH: `dbus_be` = 0011<<o, and the halfword is replicated to both halves.
  - SW: `dbus_be` = 1111.
  - `dbus_addr` = {addr[31:2], 2'b00}.
- Loads: select the byte or halfword at lane o. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.

## Timing
- Reset values:
  - State IDLE.
  - All `mem_*` outputs 0, including `mem_fault`.
  - `dbus_req`, `dbus_we`, `dbus_be` and `dbus_wdata` are 0, and `dbus_addr` is 0.
- An asserted reset forces `dbus_req` low immediately, without waiting for a clock edge.
- Latencies, with edge 0 the accepting edge:
  - Non-memory instruction or fault: outputs valid after edge 0.
  - Store: REQ from edge 0. With `dbus_ready` in cycle 1, the bundle is registered at edge 1 and visible in cycle 2.
  - Load: `dbus_rvalid` arrives no earlier than the cycle after `dbus_ready`. Minimum load latency is therefore output visible in cycle 3.
- An instruction arriving in the same cycle as `mem_stall` = 1 is not accepted.
- Reset in REQ or WAIT_RSP abandons the access. A later `dbus_rvalid` arrives in IDLE and is discarded.

## Structure
- `riscv_pkg` holds:
  - Result-source constants: ALU_RESULT 00, MEM_TO_REG 01, PC_PLUS 10.
  - funct3 encodings: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
  - The memory FSM state enum.
- One combinational sub-module, `load_store_align`: funct3 and offset in; byte enables, shifted write data, extracted load data and fault out.

## Test plan
- ALU op: rd=5, alu=0x1234 -> next cycle `mem_rd`=5, `mem_alu_result`=0x1234, `mem_wr_enable`=1, `mem_stall`=0.
- SB: addr=0x103, data=0xAB -> `dbus_be`=1000, `dbus_wdata`=0xABABABAB, `dbus_addr`=0x100. Holding `dbus_ready` low for 3 cycles keeps `mem_stall`=1 and keeps bubbles on `mem_wr_enable`.
- LB: addr=0x2, rdata=0x00800000 -> `mem_read_data`=0xFFFFFF80. Same access as LBU -> 0x00000080.
- LW: addr=0x6 -> `mem_fault` pulses, `mem_wr_enable`=0, `dbus_req` never asserted.
- Reset in WAIT_RSP, then `dbus_rvalid` next cycle -> outputs stay at reset values and state stays IDLE. A following ALU op completes in 1 cycle.
- Back-to-back LW then ADD -> the ADD is held until the load completes; writeback sees the load, then the ADD, with only bubbles between.
